fht_stream_if: RTL and testbench

- Streaming front/back end for the FHT core, covering both sides of the core's host interface.
- Load side: accepts a valid/ready sample stream, scatters the samples across the core's 4 RAM banks via bank-select WE/address writes, then pulses the core start.
- Unload side: waits for core ready, reads results back in natural index order through the 4 read ports, and emits them as a valid/ready stream with a last flag.

---
 rtl/fht_stream_if.sv | 157 +++++++++++++++
 tb/tb_fht_stream_if.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_stream_if.sv
// Streaming host interface for the FHT core: scatters a sample stream into the four RAM banks,
// starts the core, then reads results back in natural order as a valid/ready stream.
module fht_stream_if #(
  parameter int unsigned D_BIT     = 16,
  parameter int unsigned A_BIT     = 8,
  parameter int unsigned BANK_SIZE = 256
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic        [D_BIT-1:0] iIN_DATA,
  input  logic                    iIN_VALID,
  output logic                    oIN_READY,
  output logic        [3:0]       oFHT_WE,
  output logic        [D_BIT-1:0] oFHT_DATA,
  output logic        [A_BIT-1:0] oFHT_ADDR_WR,
  output logic                    oFHT_START,
  input  logic                    iFHT_RDY,
  output logic        [A_BIT-1:0] oFHT_ADDR_RD_0,
  output logic        [A_BIT-1:0] oFHT_ADDR_RD_1,
  output logic        [A_BIT-1:0] oFHT_ADDR_RD_2,
  output logic        [A_BIT-1:0] oFHT_ADDR_RD_3,
  input  logic signed [D_BIT-1:0] iFHT_DATA_0,
  input  logic signed [D_BIT-1:0] iFHT_DATA_1,
  input  logic signed [D_BIT-1:0] iFHT_DATA_2,
  input  logic signed [D_BIT-1:0] iFHT_DATA_3,
  output logic signed [D_BIT-1:0] oOUT_DATA,
  output logic                    oOUT_VALID,
  input  logic                    iOUT_READY,
  output logic                    oOUT_LAST,
  output logic                    oBUSY
);

  localparam int unsigned N  = 4 * BANK_SIZE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastIdx = CW'(N - 1);
  localparam logic [CW-1:0] NumPts  = CW'(N);

  typedef enum logic [2:0] {StLoad, StFlush, StStart, StWait, StUnload} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    ld_cnt_q, rd_cnt_q, out_cnt_q;
  logic             rdy_q;
  logic [3:0]       we_q;
  logic [A_BIT-1:0] addr_wr_q;
  logic [D_BIT-1:0] wr_data_q;
  logic             rd_vld_q;
  logic [1:0]       rd_tag_q;
  logic [D_BIT-1:0] fifo_mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;

  logic             accept, rdy_rise, out_valid, pop, push, issue, last_pop;
  logic [2:0]       slots;
  logic [D_BIT-1:0] rd_data;

  assign accept    = (state_q == StLoad) && iIN_VALID;
  assign rdy_rise  = iFHT_RDY && !rdy_q;
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && iOUT_READY;
  assign push      = rd_vld_q;
  assign last_pop  = pop && (out_cnt_q == LastIdx);

  // Slots counted after this cycle's pop so a steady pop/issue pair sustains one point per cycle.
  assign slots = {1'b0, occ_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign issue = (state_q == StUnload) && (rd_cnt_q < NumPts) && (slots < 3'd2);

  always_comb begin
    rd_data = iFHT_DATA_0;
    unique case (rd_tag_q)
      2'd0: rd_data = iFHT_DATA_0;
      2'd1: rd_data = iFHT_DATA_1;
      2'd2: rd_data = iFHT_DATA_2;
      2'd3: rd_data = iFHT_DATA_3;
      default: rd_data = iFHT_DATA_0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:   if (accept && (ld_cnt_q == LastIdx)) state_d = StFlush;
      StFlush:  state_d = StStart;
      StStart:  state_d = StWait;
      StWait:   if (rdy_rise) state_d = StUnload;
      StUnload: if (last_pop) state_d = StLoad;
      default:  state_d = StLoad;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q       <= StLoad;
      ld_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      out_cnt_q     <= '0;
      rdy_q         <= 1'b0;
      we_q          <= '0;
      addr_wr_q     <= '0;
      wr_data_q     <= '0;
      rd_vld_q      <= 1'b0;
      rd_tag_q      <= '0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= iFHT_RDY;

      we_q <= '0;
      if (accept) begin
        we_q      <= 4'b0001 << ld_cnt_q[1:0];
        addr_wr_q <= A_BIT'(ld_cnt_q >> 2);
        wr_data_q <= iIN_DATA;
        ld_cnt_q  <= (ld_cnt_q == LastIdx) ? '0 : ld_cnt_q + CW'(1);
      end

      rd_vld_q <= issue;
      if (issue) begin
        rd_tag_q <= rd_cnt_q[1:0];
        rd_cnt_q <= rd_cnt_q + CW'(1);
      end

      if (push) begin
        fifo_mem_q[wr_ptr_q] <= rd_data;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        out_cnt_q <= out_cnt_q + CW'(1);
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};

      if (last_pop) begin
        rd_cnt_q  <= '0;
        out_cnt_q <= '0;
      end
    end
  end

  assign oIN_READY      = (state_q == StLoad);
  assign oBUSY          = (state_q != StLoad);
  assign oFHT_START     = (state_q == StStart);
  assign oFHT_WE        = we_q;
  assign oFHT_ADDR_WR   = addr_wr_q;
  assign oFHT_DATA      = wr_data_q;
  assign oFHT_ADDR_RD_0 = A_BIT'(rd_cnt_q >> 2);
  assign oFHT_ADDR_RD_1 = A_BIT'(rd_cnt_q >> 2);
  assign oFHT_ADDR_RD_2 = A_BIT'(rd_cnt_q >> 2);
  assign oFHT_ADDR_RD_3 = A_BIT'(rd_cnt_q >> 2);
  assign oOUT_VALID     = out_valid;
  assign oOUT_DATA      = fifo_mem_q[rd_ptr_q];
  assign oOUT_LAST      = out_valid && (out_cnt_q == LastIdx);

endmodule

// File: tb/tb_fht_stream_if.sv
// Randomized bench for fht_stream_if with a 4-bank core model and a transaction-level reference.
module tb_fht_stream_if;

  localparam int D  = 16;
  localparam int A  = 8;
  localparam int BS = 4;
  localparam int N  = 4 * BS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, start, fht_rdy, out_valid, out_ready, out_last, busy;
  logic [D-1:0] in_data, wr_data, out_data, rd0, rd1, rd2, rd3;
  logic [3:0]   we;
  logic [A-1:0] addr_wr, ard0, ard1, ard2, ard3;

  fht_stream_if #(.D_BIT(D), .A_BIT(A), .BANK_SIZE(BS)) dut (
    .iCLK(clk), .iRESET(rst), .iIN_DATA(in_data), .iIN_VALID(in_valid), .oIN_READY(in_ready),
    .oFHT_WE(we), .oFHT_DATA(wr_data), .oFHT_ADDR_WR(addr_wr), .oFHT_START(start),
    .iFHT_RDY(fht_rdy), .oFHT_ADDR_RD_0(ard0), .oFHT_ADDR_RD_1(ard1), .oFHT_ADDR_RD_2(ard2),
    .oFHT_ADDR_RD_3(ard3), .iFHT_DATA_0(rd0), .iFHT_DATA_1(rd1), .iFHT_DATA_2(rd2),
    .iFHT_DATA_3(rd3), .oOUT_DATA(out_data), .oOUT_VALID(out_valid), .iOUT_READY(out_ready),
    .oOUT_LAST(out_last), .oBUSY(busy)
  );

  // Core model: four banks written through WE, read with one cycle of latency.
  bit           fixed;
  logic [D-1:0] mem [4][BS];
  logic [D-1:0] core_q [4];

  function automatic logic [D-1:0] core_rd(input int b, input logic [A-1:0] a);
    if (int'(a) >= BS) return '0;
    if (fixed) return D'(100 * b + int'(a));
    return mem[b][int'(a)];
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b] === 1'b1 && int'(addr_wr) < BS) mem[b][int'(addr_wr)] <= wr_data;
    end
    core_q[0] <= core_rd(0, ard0);
    core_q[1] <= core_rd(1, ard1);
    core_q[2] <= core_rd(2, ard2);
    core_q[3] <= core_rd(3, ard3);
  end
  assign rd0 = core_q[0];
  assign rd1 = core_q[1];
  assign rd2 = core_q[2];
  assign rd3 = core_q[3];

  // Reference model: phase 0 load, 1 flush, 2 start, 3 wait, 4 unload.
  int           checks, errors, cyc, acc_last_cyc, start_cyc;
  int           phase, nld, nout, ucyc;
  bit           rdy_prev, rise, hold_ready, prev_stall, just_reset, mon_en;
  logic [D-1:0] prev_data;
  logic [3:0]   e_we;
  logic [A-1:0] e_addr;
  logic [D-1:0] e_data;
  logic [D-1:0] samples [N];
  logic [D-1:0] exp_out [N];
  logic [3:0]   we_hist [$];
  logic [A-1:0] addr_hist [$];
  logic [D-1:0] out_hist [$];
  bit           last_hist [$];

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got_v, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      chk("in_ready", 32'(in_ready), 32'(phase == 0));
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("start", 32'(start), 32'(phase == 2));
      chk("we", 32'(we), 32'(e_we));
      if (e_we != 4'd0 || just_reset) begin
        chk("addr_wr", 32'(addr_wr), 32'(e_addr));
        chk("wr_data", 32'(wr_data), 32'(e_data));
      end
      if (just_reset) begin
        chk("rst_ard0", 32'(ard0), 0);
        chk("rst_ard1", 32'(ard1), 0);
        chk("rst_ard2", 32'(ard2), 0);
        chk("rst_ard3", 32'(ard3), 0);
        chk("rst_out_data", 32'(out_data), 0);
      end
      if (we != 4'd0) begin
        we_hist.push_back(we);
        addr_hist.push_back(addr_wr);
      end
      if (start) start_cyc = cyc;
      if (phase == 4) begin
        if (hold_ready) chk("valid_timing", 32'(out_valid), 32'(ucyc >= 2));
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid) begin
          chk("out_data", 32'(out_data), 32'(exp_out[nout]));
          chk("out_last", 32'(out_last), 32'(nout == N - 1));
          if (out_ready) begin
            out_hist.push_back(out_data);
            last_hist.push_back(out_last);
          end
        end
      end else begin
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_last", 32'(out_last), 0);
      end
    end
    just_reset = 1'b0;
    if (rst) begin
      phase = 0; nld = 0; nout = 0; ucyc = 0; rdy_prev = 1'b0; prev_stall = 1'b0;
      e_we = '0; e_addr = '0; e_data = '0; just_reset = 1'b1; mon_en = 1'b1;
    end else if (mon_en) begin
      e_we = '0;
      rise = fht_rdy && !rdy_prev;
      rdy_prev = fht_rdy;
      case (phase)
        0: if (in_valid) begin
          e_we = 4'(1 << (nld % 4));
          e_addr = A'(nld / 4);
          e_data = in_data;
          samples[nld] = in_data;
          if (nld == N - 1) begin
            acc_last_cyc = cyc;
            phase = 1;
            nld = 0;
          end else nld++;
        end
        1: phase = 2;
        2: phase = 3;
        3: if (rise) begin
          phase = 4;
          ucyc = 0;
          for (int k = 0; k < N; k++)
            exp_out[k] = fixed ? D'(100 * (k % 4) + k / 4) : samples[k];
        end
        4: begin
          prev_stall = out_valid && !out_ready;
          prev_data = out_data;
          if (out_valid && out_ready) begin
            if (nout == N - 1) begin
              phase = 0;
              nout = 0;
            end else nout++;
          end
          ucyc++;
        end
        default: phase = 0;
      endcase
      if (phase != 4) prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired in phase %0d (cycle %0d)", name, phase, cyc);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_run(input bit gapped, input bit seq, input int stop_at);
    int budget = 0;
    while (phase == 0 && nld < stop_at && budget < 200) begin
      in_valid = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = seq ? D'(nld) : D'($urandom);
      tick();
      budget++;
    end
    in_valid = 1'b0;
    if (budget >= 200) timeout("load");
  endtask

  task automatic wait_phase(input int p);
    int budget = 0;
    while (phase != p && budget < 50) begin
      tick();
      budget++;
    end
    if (budget >= 50) timeout("wait_phase");
  endtask

  task automatic unload_run(input bit bp, input int stop_out, input bit wait_valid);
    int budget = 0;
    if (wait_valid) begin
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        in_data = D'($urandom);
        tick();
      end
      in_valid = 1'b0;
    end
    fht_rdy = 1'b0;
    tick();
    tick();
    hold_ready = !bp;
    out_ready = 1'b1;
    fht_rdy = 1'b1;
    tick();
    while (phase != 0 && !(stop_out > 0 && nout >= stop_out) && budget < 300) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget++;
    end
    if (budget >= 300) timeout("unload");
    out_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; fht_rdy = 1'b0; out_ready = 1'b1;
    fixed = 1'b0; hold_ready = 1'b0;
    checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Samples 0..15 back to back, core answers 100*bank+addr, sink always ready.
    fixed = 1'b1;
    we_hist.delete(); addr_hist.delete(); out_hist.delete(); last_hist.delete();
    load_run(1'b0, 1'b1, N);
    wait_phase(3);
    unload_run(1'b0, 0, 1'b0);
    tick();
    chk("lit_we_count", 32'(we_hist.size()), 16);
    chk("lit_we0", 32'(we_hist[0]), 32'h1);
    chk("lit_we5", 32'(we_hist[5]), 32'h2);
    chk("lit_we15", 32'(we_hist[15]), 32'h8);
    chk("lit_addr5", 32'(addr_hist[5]), 1);
    chk("lit_addr15", 32'(addr_hist[15]), 3);
    chk("lit_start_delay", 32'(start_cyc - acc_last_cyc), 2);
    chk("lit_out_count", 32'(out_hist.size()), 16);
    chk("lit_out1", 32'(out_hist[1]), 100);
    chk("lit_out4", 32'(out_hist[4]), 1);
    chk("lit_out15", 32'(out_hist[15]), 303);
    chk("lit_last14", 32'(last_hist[14]), 0);
    chk("lit_last15", 32'(last_hist[15]), 1);

    // RDY still high from the last run: gapped load, valid during WAIT, random backpressure.
    fixed = 1'b0;
    out_hist.delete();
    load_run(1'b1, 1'b0, N);
    wait_phase(3);
    unload_run(1'b1, 0, 1'b1);
    chk("bp_out_count", 32'(out_hist.size()), 16);

    // Reset after 7 samples, then a fresh load must start at bank 0 address 0.
    load_run(1'b1, 1'b0, 7);
    do_reset();
    we_hist.delete(); addr_hist.delete();
    load_run(1'b1, 1'b0, N);
    chk("fresh_we0", 32'(we_hist[0]), 32'h1);
    chk("fresh_addr0", 32'(addr_hist[0]), 0);

    // Reset after 5 output points.
    wait_phase(3);
    unload_run(1'b1, 5, 1'b0);
    do_reset();

    for (int r = 0; r < 4; r++) begin
      out_hist.delete();
      load_run(r[0], 1'b0, N);
      wait_phase(3);
      unload_run(r[1], 0, r[0]);
      chk("run_out_count", 32'(out_hist.size()), 16);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
